// File: rtl/image_framer_pkg.sv
// Shared definitions for the image framer and the classifier it feeds:
// bitmap geometry, default pixel width and the framer FSM state type.
package image_framer_pkg;

  localparam int LENGTH = 8;
  localparam int WIDTH  = 8;
  localparam int PIX_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FIRE = 2'd2,
    HOLD = 2'd3
  } framer_state_t;

endpackage

// File: rtl/image_framer_cursor.sv
// Row-major write cursor over the LENGTH x WIDTH bitmap, with load-zero,
// advance and a flag marking the final pixel position.
module framer_cursor #(
  parameter int LENGTH = image_framer_pkg::LENGTH,
  parameter int WIDTH  = image_framer_pkg::WIDTH,
  parameter int ROW_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1,
  parameter int COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_zero,
  input  logic             advance,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(LENGTH - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(WIDTH - 1);

  logic [ROW_W-1:0] row_reg, row_next, row_base;
  logic [COL_W-1:0] col_reg, col_next, col_base;

  // Load-zero and advance together land on the pixel after (0,0).
  always_comb begin
    row_base = load_zero ? '0 : row_reg;
    col_base = load_zero ? '0 : col_reg;
    row_next = row_base;
    col_next = col_base;
    if (advance) begin
      if (col_base == COL_MAX) begin
        col_next = '0;
        row_next = (row_base == ROW_MAX) ? '0 : row_base + 1'b1;
      end else begin
        col_next = col_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_reg <= '0;
      col_reg <= '0;
    end else begin
      row_reg <= row_next;
      col_reg <= col_next;
    end
  end

  assign row  = row_reg;
  assign col  = col_reg;
  assign last = (row_reg == ROW_MAX) && (col_reg == COL_MAX);

endmodule

// File: rtl/image_framer.sv
// Binarizes a serial grayscale stream into a LENGTH x WIDTH bitmap, strobes
// init_out when a full frame is present and freezes it for HOLD_CYCLES.
module image_framer #(
  parameter int LENGTH      = image_framer_pkg::LENGTH,
  parameter int WIDTH       = image_framer_pkg::WIDTH,
  parameter int PIX_W       = image_framer_pkg::PIX_W,
  parameter int THRESH      = 128,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pix_valid,
  input  logic                          pix_sof,
  input  logic [PIX_W-1:0]              pix_data,
  output logic                          pix_ready,
  output logic [LENGTH-1:0][WIDTH-1:0]  image,
  output logic                          init_out,
  output logic                          frame_err,
  output logic                          busy
);

  import image_framer_pkg::*;

  localparam int ROW_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  framer_state_t    state_reg, state_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic             init_reg, err_reg;

  logic [ROW_W-1:0] cur_row, wr_row;
  logic [COL_W-1:0] cur_col, wr_col;
  logic             cur_last;
  logic             load_zero, advance, wr_en, pix_bit;

  assign pix_bit = (pix_data >= PIX_W'(THRESH));

  framer_cursor #(
    .LENGTH (LENGTH),
    .WIDTH  (WIDTH),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W)
  ) u_cursor (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_zero (load_zero),
    .advance   (advance),
    .row       (cur_row),
    .col       (cur_col),
    .last      (cur_last)
  );

  // pix_valid is used directly in states where pix_ready is 1, so the
  // handshake decode does not loop back through pix_ready.
  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    pix_ready  = 1'b0;
    busy       = 1'b0;
    wr_en      = 1'b0;
    load_zero  = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      IDLE: begin
        pix_ready = 1'b1;
        if (pix_valid && pix_sof) begin
          wr_en      = 1'b1;
          load_zero  = 1'b1;
          advance    = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        if (pix_valid) begin
          wr_en   = 1'b1;
          advance = 1'b1;
          if (pix_sof) begin
            load_zero = 1'b1;
          end else if (cur_last) begin
            state_next = FIRE;
          end
        end
      end
      FIRE: begin
        busy       = 1'b1;
        hold_next  = HOLD_W'(HOLD_CYCLES - 1);
        state_next = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        if (hold_reg == '0) begin
          state_next = IDLE;
        end else begin
          hold_next = hold_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
      init_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      init_reg  <= (state_reg == FILL) && (state_next == FIRE);
      err_reg   <= (state_reg == FILL) && pix_valid && pix_sof;
    end
  end

  assign wr_row = load_zero ? '0 : cur_row;
  assign wr_col = load_zero ? '0 : cur_col;

  genvar gi;
  generate
    for (gi = 0; gi < LENGTH; gi++) begin : g_row
      logic [WIDTH-1:0] row_reg;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          row_reg <= '0;
        end else if (wr_en && (wr_row == ROW_W'(gi))) begin
          row_reg[wr_col] <= pix_bit;
        end
      end
      assign image[gi] = row_reg;
    end
  endgenerate

  assign init_out  = init_reg;
  assign frame_err = err_reg;

endmodule

// File: tb/tb_image_framer.sv
// Directed bench for image_framer: a pixel-index model predicts every output
// each cycle, and literal checks pin bitmap contents and strobe counts.
module tb_image_framer;

  localparam int LENGTH = 4;
  localparam int WIDTH  = 4;
  localparam int PIX_W  = 8;
  localparam int THRESH = 128;
  localparam int HOLD   = 3;
  localparam int NPIX   = LENGTH * WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  logic pix_valid, pix_sof;
  logic [PIX_W-1:0] pix_data;
  logic pix_ready, init_out, frame_err, busy;
  logic [LENGTH-1:0][WIDTH-1:0] image;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_init, cnt_nready, cnt_err;
  bit started = 1'b0;

  always #5 clk = ~clk;

  image_framer #(
    .LENGTH      (LENGTH),
    .WIDTH       (WIDTH),
    .PIX_W       (PIX_W),
    .THRESH      (THRESH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .image     (image),
    .init_out  (init_out),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Model: frame progress as a pixel index k, plus a blocked-cycle countdown.
  logic [NPIX-1:0] m_img;
  int  m_k, m_block;
  bit  m_in, m_init, m_err;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_img <= '0; m_k <= 0; m_in <= 0; m_block <= 0; m_init <= 0; m_err <= 0;
    end else begin
      m_init <= 0;
      m_err  <= 0;
      if (pix_valid && m_block == 0) begin
        if (pix_sof) begin
          m_err    <= m_in;
          m_img[0] <= (pix_data >= THRESH);
          m_k      <= 1;
          m_in     <= 1;
        end else if (m_in) begin
          m_img[m_k] <= (pix_data >= THRESH);
          if (m_k == NPIX - 1) begin
            m_in    <= 0;
            m_k     <= 0;
            m_block <= 1 + HOLD;
            m_init  <= 1;
          end else begin
            m_k <= m_k + 1;
          end
        end
      end else if (m_block != 0) begin
        m_block <= m_block - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("pix_ready", {31'b0, pix_ready}, {31'b0, m_block == 0});
      chk("busy",      {31'b0, busy},      {31'b0, m_in || m_block != 0});
      chk("init_out",  {31'b0, init_out},  {31'b0, m_init});
      chk("frame_err", {31'b0, frame_err}, {31'b0, m_err});
      chk("image",     {16'b0, image},     {16'b0, m_img});
    end
  end

  task automatic step(input logic v, input logic s, input logic [PIX_W-1:0] d);
    @(negedge clk);
    cnt_init   += int'(init_out);
    cnt_nready += int'(!pix_ready);
    cnt_err    += int'(frame_err);
    pix_valid = v;
    pix_sof   = s;
    pix_data  = d;
  endtask

  task automatic clr_counts();
    cnt_init = 0; cnt_nready = 0; cnt_err = 0;
  endtask

  initial begin
    rst_n = 1'b0; pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 8'hFF;
    clr_counts();
    @(posedge clk);
    started = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; pix_valid = 1'b0;
    chk("rst_image", {16'b0, image}, 32'h0);
    chk("rst_ready", {31'b0, pix_ready}, 32'h1);
    chk("rst_busy",  {31'b0, busy}, 32'h0);
    chk("rst_init",  {31'b0, init_out}, 32'h0);
    $display("reset released: image=%h ready=%b busy=%b", image, pix_ready, busy);

    // Full frame alternating 0x00/0xFF
    clr_counts();
    for (int i = 0; i < NPIX; i++) step(1'b1, i == 0, (i % 2 == 1) ? 8'hFF : 8'h00);
    repeat (8) step(1'b0, 1'b0, 8'h00);
    chk("alt_image", {16'b0, image}, 32'hAAAA);
    chk("alt_init_count", cnt_init, 1);
    chk("alt_notready_cycles", cnt_nready, 1 + HOLD);
    chk("alt_err_count", cnt_err, 0);
    $display("frame alt: image=%h init=%0d notready=%0d", image, cnt_init, cnt_nready);

    // Threshold edges
    for (int i = 0; i < NPIX; i++) step(1'b1, i == 0, 8'h80);
    repeat (6) step(1'b0, 1'b0, 8'h00);
    chk("thr_80_image", {16'b0, image}, 32'hFFFF);
    $display("frame 0x80: image=%h", image);
    for (int i = 0; i < NPIX; i++) step(1'b1, i == 0, 8'h7F);
    repeat (6) step(1'b0, 1'b0, 8'h00);
    chk("thr_7f_image", {16'b0, image}, 32'h0000);
    $display("frame 0x7F: image=%h", image);

    // Abort: sof arrives as pixel index 7
    clr_counts();
    for (int i = 0; i < 7; i++) step(1'b1, i == 0, 8'hFF);
    for (int i = 0; i < NPIX; i++) begin
      if (i == NPIX - 1) chk("abort_no_early_init", cnt_init, 0);
      step(1'b1, i == 0, (i < 8) ? 8'h00 : 8'hFF);
    end
    repeat (6) step(1'b0, 1'b0, 8'h00);
    chk("abort_err_count", cnt_err, 1);
    chk("abort_init_count", cnt_init, 1);
    chk("abort_image", {16'b0, image}, 32'hFF00);
    $display("abort frame: image=%h err=%0d init=%0d", image, cnt_err, cnt_init);

    // Backpressure and idle junk: valid held high with zero data after the frame
    clr_counts();
    for (int i = 0; i < NPIX; i++) step(1'b1, i == 0, (i % 4 == 0) ? 8'hFF : 8'h00);
    repeat (10) step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("bp_image", {16'b0, image}, 32'h1111);
    chk("bp_init_count", cnt_init, 1);
    chk("bp_err_count", cnt_err, 0);
    $display("backpressure: image=%h init=%0d err=%0d", image, cnt_init, cnt_err);

    // Reset mid-FILL after 9 pixels, then a normal frame
    clr_counts();
    for (int i = 0; i < 9; i++) step(1'b1, i == 0, 8'hFF);
    step(1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 8'hFF);
    step(1'b1, 1'b0, 8'hFF);
    rst_n = 1'b1;
    pix_valid = 1'b0;
    repeat (3) step(1'b0, 1'b0, 8'h00);
    chk("midrst_image", {16'b0, image}, 32'h0);
    chk("midrst_init_count", cnt_init, 0);
    chk("midrst_err_count", cnt_err, 0);
    $display("mid-fill reset: image=%h init=%0d err=%0d", image, cnt_init, cnt_err);
    for (int i = 0; i < NPIX; i++) step(1'b1, i == 0, (i % 2 == 1) ? 8'hFF : 8'h00);
    repeat (8) step(1'b0, 1'b0, 8'h00);
    chk("post_rst_image", {16'b0, image}, 32'hAAAA);
    chk("post_rst_init_count", cnt_init, 1);
    $display("frame after reset: image=%h init=%0d", image, cnt_init);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
